fifo_row_loader: RTL and testbench

Consumer stage placed directly downstream of the team's single-word FIFO. It drains the FIFO one word at a time and packs `row_len` consecutive words into one parallel row vector. Each packed row is presented to a systolic PE row or weight register bank with a valid/ready handshake. It repeats for a programmed number of rows per `start` command, then pulses `done`.

---
 rtl/fifo_row_loader.sv | 118 +++++++++++
 tb/tb_fifo_row_loader.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_row_loader.sv
// Drains a single-word FIFO and packs row_len words into one row vector,
// repeating for num_rows rows per start command, then pulses done.
module fifo_row_loader #(
    parameter int data_size = 8,
    parameter int row_len   = 4,
    parameter int cnt_bits  = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          start,
    input  logic [cnt_bits-1:0]           num_rows,
    input  logic                          fifo_empty,
    input  logic [data_size-1:0]          fifo_data,
    output logic                          fifo_rd_en,
    output logic [row_len*data_size-1:0]  row_data,
    output logic                          row_valid,
    input  logic                          row_ready,
    output logic                          busy,
    output logic                          done
);

    localparam int iw = $clog2(row_len + 1);
    localparam logic [iw-1:0] row_len_c = iw'(row_len);
    localparam logic [iw-1:0] last_c    = iw'(row_len - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        PRESENT,
        FINISH
    } state_t;

    state_t              state;
    logic [cnt_bits-1:0] rows_q;
    logic [cnt_bits-1:0] rows_done;
    logic [cnt_bits:0]   rows_next;
    logic [iw-1:0]       issued;
    logic [iw-1:0]       captured;
    logic                pending;

    assign rows_next = {1'b0, rows_done} + 1'b1;

    // Gated by reset so no word is popped on a cycle whose edge resets us.
    assign fifo_rd_en = ~reset & (state == FETCH) & ~fifo_empty
                      & (issued < row_len_c);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rows_q    <= '0;
            rows_done <= '0;
            issued    <= '0;
            captured  <= '0;
            pending   <= 1'b0;
            row_data  <= '0;
            row_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        rows_q    <= num_rows;
                        rows_done <= '0;
                        issued    <= '0;
                        captured  <= '0;
                        pending   <= 1'b0;
                        busy      <= 1'b1;
                        if (num_rows == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                FETCH: begin
                    if (fifo_rd_en)
                        issued <= issued + 1'b1;
                    pending <= fifo_rd_en;
                    // Read data lags the request by one cycle.
                    if (pending) begin
                        for (int k = 0; k < row_len; k++) begin
                            if (int'(captured) == k)
                                row_data[k*data_size +: data_size] <= fifo_data;
                        end
                        captured <= captured + 1'b1;
                        if (captured == last_c) begin
                            state     <= PRESENT;
                            row_valid <= 1'b1;
                        end
                    end
                end
                PRESENT: begin
                    if (row_valid && row_ready) begin
                        row_valid <= 1'b0;
                        rows_done <= rows_done + 1'b1;
                        if (rows_next == {1'b0, rows_q}) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else begin
                            issued   <= '0;
                            captured <= '0;
                            state    <= FETCH;
                        end
                    end
                end
                FINISH: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_row_loader.sv
// Scoreboard bench for fifo_row_loader with a behavioural 1-cycle-latency FIFO.
module tb_fifo_row_loader;

    localparam int DW = 8;
    localparam int RL = 4;
    localparam int CB = 8;

    logic              clk = 0;
    logic              reset;
    logic              start;
    logic [CB-1:0]     num_rows;
    logic              fifo_empty;
    logic [DW-1:0]     fifo_data;
    logic              fifo_rd_en;
    logic [RL*DW-1:0]  row_data;
    logic              row_valid;
    logic              row_ready;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int reads = 0;
    int dones = 0;

    logic [DW-1:0]    fq[$];
    logic [RL*DW-1:0] exp_q[$];

    fifo_row_loader #(.data_size(DW), .row_len(RL), .cnt_bits(CB)) dut (
        .clk(clk), .reset(reset), .start(start), .num_rows(num_rows),
        .fifo_empty(fifo_empty), .fifo_data(fifo_data),
        .fifo_rd_en(fifo_rd_en), .row_data(row_data),
        .row_valid(row_valid), .row_ready(row_ready),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // FIFO model: registered read data, pushes only happen away from posedge.
    always @(posedge clk) begin
        if (fifo_rd_en && !fifo_empty) begin
            fifo_data <= fq.pop_front();
            reads++;
            fifo_empty <= (fq.size() == 0);
        end
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [DW-1:0] w);
        fq.push_back(w);
        fifo_empty = 0;
    endtask

    // Monitor: pops expected rows on each handshake and checks hold behaviour.
    logic [RL*DW-1:0] prev_data;
    logic             prev_hold = 0;
    always @(negedge clk) begin
        if (done) dones++;
        if (row_valid) begin
            chk("rd_en_while_valid", 64'(fifo_rd_en), 64'd0);
            if (prev_hold)
                chk("row_stable", 64'(row_data), 64'(prev_data));
            if (row_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_row", 64'(row_data), 64'hDEAD);
                end else begin
                    chk("row_data", 64'(row_data), 64'(exp_q.pop_front()));
                end
            end
        end
        prev_hold = row_valid && !row_ready && !reset;
        prev_data = row_data;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pulse_start(input logic [CB-1:0] n);
        num_rows = n;
        start = 1;
        tick(1);
        start = 0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            if (!busy) break;
            tick(1);
        end
        chk(name, 64'(busy), 64'd0);
    endtask

    int r0, d0;

    initial begin
        reset = 1; start = 0; num_rows = 0; row_ready = 1;
        fifo_empty = 1; fifo_data = 0;
        tick(2);
        chk("rst_valid", 64'(row_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_data", 64'(row_data), 64'd0);
        chk("rst_rden", 64'(fifo_rd_en), 64'd0);
        reset = 0;
        tick(1);

        // Two rows back to back, FIFO preloaded.
        for (int i = 1; i <= 8; i++) push(8'(i));
        exp_q.push_back(32'h04030201);
        exp_q.push_back(32'h08070605);
        r0 = reads; d0 = dones;
        pulse_start(2);
        wait_idle("t1_idle", 100);
        tick(1);
        chk("t1_reads", 64'(reads - r0), 64'd8);
        chk("t1_dones", 64'(dones - d0), 64'd1);
        chk("t1_empty", 64'(fifo_empty), 64'd1);

        // Underflow stall, then refill.
        push(8'hAA); push(8'hBB);
        exp_q.push_back(32'hDDCCBBAA);
        pulse_start(1);
        tick(10);
        chk("t2_stall_valid", 64'(row_valid), 64'd0);
        chk("t2_stall_rden", 64'(fifo_rd_en), 64'd0);
        chk("t2_stall_busy", 64'(busy), 64'd1);
        push(8'hCC); push(8'hDD);
        wait_idle("t2_idle", 100);
        tick(1);

        // Backpressure.
        row_ready = 0;
        for (int i = 0; i < 8; i++) push(8'(8'h21 + i));
        exp_q.push_back(32'h24232221);
        exp_q.push_back(32'h28272625);
        r0 = reads;
        pulse_start(2);
        for (int i = 0; i < 50; i++) begin
            if (row_valid) break;
            tick(1);
        end
        chk("t3_valid_seen", 64'(row_valid), 64'd1);
        tick(5);
        chk("t3_hold_valid", 64'(row_valid), 64'd1);
        chk("t3_hold_reads", 64'(reads - r0), 64'd4);
        row_ready = 1;
        wait_idle("t3_idle", 100);
        tick(1);
        chk("t3_reads", 64'(reads - r0), 64'd8);

        // Zero rows.
        r0 = reads; d0 = dones;
        pulse_start(0);
        chk("t4_done", 64'(done), 64'd1);
        wait_idle("t4_idle", 10);
        tick(1);
        chk("t4_reads", 64'(reads - r0), 64'd0);
        chk("t4_dones", 64'(dones - d0), 64'd1);

        // Reset with a partial row.
        push(8'h51); push(8'h52);
        pulse_start(1);
        tick(6);
        reset = 1;
        tick(1);
        reset = 0;
        chk("t5_valid", 64'(row_valid), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        chk("t5_data", 64'(row_data), 64'd0);
        chk("t5_rden", 64'(fifo_rd_en), 64'd0);
        for (int i = 0; i < 4; i++) push(8'(8'h10 + i));
        exp_q.push_back(32'h13121110);
        pulse_start(1);
        wait_idle("t5_idle", 100);
        tick(1);

        // Start while busy must be ignored.
        for (int i = 0; i < 8; i++) push(8'(8'h31 + i));
        exp_q.push_back(32'h34333231);
        exp_q.push_back(32'h38373635);
        r0 = reads; d0 = dones;
        pulse_start(2);
        tick(2);
        pulse_start(5);
        num_rows = 0;
        wait_idle("t6_idle", 100);
        tick(20);
        chk("t6_busy", 64'(busy), 64'd0);
        chk("t6_reads", 64'(reads - r0), 64'd8);
        chk("t6_dones", 64'(dones - d0), 64'd1);
        chk("rows_left", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
